// File: rtl/nand_bus_seq.sv
// NAND bus cycle sequencer: runs one primitive pin operation (CMD/ADDR/WR/RD/
// WAIT_RB/CE_OFF) per request with programmable clock-count strobe timing.
module nand_bus_seq #(
    parameter int unsigned T_WP        = 2,
    parameter int unsigned T_WH        = 1,
    parameter int unsigned T_RP        = 2,
    parameter int unsigned T_REH       = 1,
    parameter int unsigned T_WB        = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic       FAB_CCC_GL0,
    input  logic       FAB_RESET_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic       req_cs,
    input  logic [7:0] req_data,
    input  logic       wp_en_n,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic       nand_rnb,
    input  logic       nand_rnb2,
    output logic       nand_cle,
    output logic       nand_ale,
    output logic       nand_nwe,
    output logic       nand_nre,
    output logic       nand_nce,
    output logic       nand_nce2,
    output logic       nand_nwp,
    output logic [7:0] data_o,
    output logic       data_oe,
    input  logic [7:0] data_i
);

    localparam int unsigned WP_EFF  = (T_WP == 0) ? 1 : T_WP;
    localparam int unsigned WH_EFF  = (T_WH == 0) ? 1 : T_WH;
    localparam int unsigned RP_EFF  = (T_RP == 0) ? 1 : T_RP;
    localparam int unsigned REH_EFF = (T_REH == 0) ? 1 : T_REH;
    localparam int unsigned WB_EFF  = (T_WB == 0) ? 1 : T_WB;
    localparam int unsigned TO_EFF  = (TIMEOUT_CYC == 0) ? 1 : TIMEOUT_CYC;

    localparam logic [19:0] WP_M1  = 20'(WP_EFF - 1);
    localparam logic [19:0] WH_M1  = 20'(WH_EFF - 1);
    localparam logic [19:0] RP_M1  = 20'(RP_EFF - 1);
    localparam logic [19:0] REH_M1 = 20'(REH_EFF - 1);
    localparam logic [19:0] WB_M1  = 20'(WB_EFF - 1);
    localparam logic [19:0] TO_M1  = 20'(TO_EFF - 1);

    typedef enum logic [2:0] {
        IDLE, WE_LO, WE_HI, RE_LO, RE_HI, WB, POLL, DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_CMD, OP_ADDR, OP_WR, OP_RD, OP_WAIT, OP_CEOFF
    } op_t;

    state_t      state;
    logic [19:0] cnt;
    logic        cs_q;
    logic [1:0]  rb_s1;
    logic [1:0]  rb_s2;

    always_ff @(posedge FAB_CCC_GL0) begin
        if (!FAB_RESET_N) begin
            state     <= IDLE;
            cnt       <= '0;
            cs_q      <= 1'b0;
            rb_s1     <= '0;
            rb_s2     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            nand_cle  <= 1'b0;
            nand_ale  <= 1'b0;
            nand_nwe  <= 1'b1;
            nand_nre  <= 1'b1;
            nand_nce  <= 1'b1;
            nand_nce2 <= 1'b1;
            nand_nwp  <= 1'b0;
            data_o    <= '0;
            data_oe   <= 1'b0;
        end else begin
            nand_nwp  <= wp_en_n;
            rb_s1     <= {nand_rnb2, nand_rnb};
            rb_s2     <= rb_s1;
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        cs_q      <= req_cs;
                        nand_nce  <= req_cs;
                        nand_nce2 <= ~req_cs;
                        case (req_op)
                            OP_CMD, OP_ADDR, OP_WR: begin
                                state    <= WE_LO;
                                cnt      <= WP_M1;
                                nand_nwe <= 1'b0;
                                nand_cle <= (req_op == OP_CMD);
                                nand_ale <= (req_op == OP_ADDR);
                                data_oe  <= 1'b1;
                                data_o   <= req_data;
                            end
                            OP_RD: begin
                                state    <= RE_LO;
                                cnt      <= RP_M1;
                                nand_nre <= 1'b0;
                                data_oe  <= 1'b0;
                            end
                            OP_WAIT: begin
                                state <= WB;
                                cnt   <= WB_M1;
                            end
                            // CE_OFF and illegal ops spend their single busy
                            // clock in WE_HI with a zero count; nwe is already high.
                            OP_CEOFF: begin
                                state     <= WE_HI;
                                cnt       <= '0;
                                nand_nce  <= 1'b1;
                                nand_nce2 <= 1'b1;
                            end
                            default: begin
                                state   <= WE_HI;
                                cnt     <= '0;
                                rsp_err <= 1'b1;
                            end
                        endcase
                    end
                end
                WE_LO: begin
                    if (cnt == '0) begin
                        state    <= WE_HI;
                        cnt      <= WH_M1;
                        nand_nwe <= 1'b1;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                WE_HI, RE_HI: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        nand_cle  <= 1'b0;
                        nand_ale  <= 1'b0;
                        data_oe   <= 1'b0;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                RE_LO: begin
                    if (cnt == '0) begin
                        state    <= RE_HI;
                        cnt      <= REH_M1;
                        nand_nre <= 1'b1;
                        rsp_data <= data_i;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                WB: begin
                    if (cnt == '0) begin
                        state <= POLL;
                        cnt   <= TO_M1;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                POLL: begin
                    if (rb_s2[cs_q]) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end else if (cnt == '0) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_bus_seq.sv
// Randomized bench for nand_bus_seq: each request is expanded into the expected
// per-clock pin trace from the timing rules and compared cycle by cycle.
module tb_nand_bus_seq;

    localparam int unsigned WP  = 2;
    localparam int unsigned WH  = 1;
    localparam int unsigned RP  = 2;
    localparam int unsigned REH = 1;
    localparam int unsigned WB  = 4;
    localparam int unsigned TO  = 16;

    logic       clk;
    logic       FAB_RESET_N;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic       req_cs;
    logic [7:0] req_data;
    logic       wp_en_n;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       nand_rnb;
    logic       nand_rnb2;
    logic       nand_cle;
    logic       nand_ale;
    logic       nand_nwe;
    logic       nand_nre;
    logic       nand_nce;
    logic       nand_nce2;
    logic       nand_nwp;
    logic [7:0] data_o;
    logic       data_oe;
    logic [7:0] data_i;

    nand_bus_seq #(
        .T_WP(WP), .T_WH(WH), .T_RP(RP), .T_REH(REH), .T_WB(WB), .TIMEOUT_CYC(TO)
    ) dut (
        .FAB_CCC_GL0(clk),
        .FAB_RESET_N(FAB_RESET_N),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_cs(req_cs),
        .req_data(req_data),
        .wp_en_n(wp_en_n),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .nand_rnb(nand_rnb),
        .nand_rnb2(nand_rnb2),
        .nand_cle(nand_cle),
        .nand_ale(nand_ale),
        .nand_nwe(nand_nwe),
        .nand_nre(nand_nre),
        .nand_nce(nand_nce),
        .nand_nce2(nand_nce2),
        .nand_nwp(nand_nwp),
        .data_o(data_o),
        .data_oe(data_oe),
        .data_i(data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic       cle;
        logic       ale;
        logic       nwe;
        logic       nre;
        logic       oe;
        logic       rv;
        logic       err;
        logic [7:0] dout;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    logic m_nce   = 1'b1;
    logic m_nce2  = 1'b1;
    logic [7:0] m_rdata = '0;
    logic wp_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic ready, input logic cle, input logic ale,
                                input logic nwe, input logic nre, input logic oe,
                                input logic rv, input logic err, input logic [7:0] dout);
        exp_t e;
        e.ready = ready; e.cle = cle; e.ale = ale; e.nwe = nwe; e.nre = nre;
        e.oe = oe; e.rv = rv; e.err = err; e.dout = dout;
        return e;
    endfunction

    // One clock; nwp is expected to follow wp_en_n as seen at that edge.
    task automatic step();
        logic r;
        logic w;
        r = !FAB_RESET_N;
        w = wp_en_n;
        @(posedge clk);
        @(negedge clk);
        wp_last = r ? 1'b0 : w;
    endtask

    task automatic check_cycle(input exp_t e, input string tag);
        logic [8:0] g;
        logic [8:0] x;
        g = {req_ready, nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nce2, data_oe, rsp_valid};
        x = {e.ready, e.cle, e.ale, e.nwe, e.nre, m_nce, m_nce2, e.oe, e.rv};
        chk({tag, ".pins"}, 32'(g), 32'(x));
        if (e.oe) chk({tag, ".data_o"}, 32'(data_o), 32'(e.dout));
        if (e.rv) begin
            chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(m_rdata));
            chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(e.err));
        end
        chk({tag, ".nwp"}, 32'(nand_nwp), 32'(wp_last));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".pins"},
            32'({req_ready, nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nce2, data_oe, rsp_valid}),
            32'(9'b100111100));
        chk({tag, ".data_o"}, 32'(data_o), 32'h0);
        chk({tag, ".rsp_data"}, 32'(rsp_data), 32'h0);
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, ".nwp"}, 32'(nand_nwp), 32'h0);
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            req_valid = 1'b0;
            data_i    = 8'($urandom);
            wp_en_n   = 1'($urandom);
            step();
            check_cycle(mk(1, 0, 0, 1, 1, 0, 0, 0, 8'h00), "idle");
        end
    endtask

    task automatic set_rb(input logic cs, input logic v);
        if (cs) nand_rnb2 = v;
        else    nand_rnb  = v;
    endtask

    // d: edge offset (from accept) at which the selected R/B pin reads 1.
    task automatic run_op(input int op, input logic cs, input logic [7:0] dat,
                          input logic [7:0] rbyte, input int d, input bit hold,
                          input int abort);
        exp_t  tr[$];
        string tag;
        int    nmin;
        int    e_exit;
        logic  e_err;
        tag = $sformatf("op%0d", op);
        if (op == 4) begin
            set_rb(cs, 1'b0);
            set_rb(!cs, 1'b1);
            idle_cycles(2);
        end
        case (op)
            0, 1, 2: begin
                repeat (WP) tr.push_back(mk(0, op == 0, op == 1, 0, 1, 1, 0, 0, dat));
                repeat (WH) tr.push_back(mk(0, op == 0, op == 1, 1, 1, 1, 0, 0, dat));
                tr.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 8'h00));
            end
            3: begin
                repeat (RP)  tr.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 8'h00));
                repeat (REH) tr.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8'h00));
                tr.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 8'h00));
            end
            4: begin
                // R/B reaches the poll logic two edges after the pin; the
                // first poll edge is WB+1 after accept.
                nmin = d + 2 - int'(WB);
                if (nmin < 1) nmin = 1;
                if (nmin <= int'(TO)) begin
                    e_exit = int'(WB) + nmin;
                    e_err  = 1'b0;
                end else begin
                    e_exit = int'(WB + TO);
                    e_err  = 1'b1;
                end
                repeat (e_exit) tr.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8'h00));
                tr.push_back(mk(0, 0, 0, 1, 1, 0, 1, e_err, 8'h00));
            end
            5: begin
                tr.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8'h00));
                tr.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 8'h00));
            end
            default: begin
                tr.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8'h00));
                tr.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 8'h00));
            end
        endcase
        tr.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 8'h00));

        if (op == 5) begin
            m_nce  = 1'b1;
            m_nce2 = 1'b1;
        end else begin
            m_nce  = cs;
            m_nce2 = !cs;
        end
        if (op == 3) m_rdata = rbyte;

        req_valid = 1'b1;
        req_op    = 3'(op);
        req_cs    = cs;
        req_data  = dat;
        data_i    = 8'($urandom);
        if (op == 4) set_rb(cs, d <= 0);

        for (int i = 0; i < tr.size(); i++) begin
            step();
            check_cycle(tr[i], tag);
            if (i == abort) begin
                FAB_RESET_N = 1'b0;
                req_valid   = 1'b0;
                step();
                check_reset("abort");
                FAB_RESET_N = 1'b1;
                m_nce   = 1'b1;
                m_nce2  = 1'b1;
                m_rdata = '0;
                return;
            end
            if (!hold) req_valid = 1'b0;
            if (i < tr.size() - 1) begin
                req_op   = 3'($urandom);
                req_cs   = 1'($urandom);
                req_data = 8'($urandom);
            end
            data_i  = (op == 3 && i == int'(RP) - 1) ? rbyte : 8'($urandom);
            if (op == 4) set_rb(cs, (i + 1) >= d);
            wp_en_n = 1'($urandom);
        end
    endtask

    initial begin
        FAB_RESET_N = 1'b0;
        req_valid   = 1'b0;
        req_op      = '0;
        req_cs      = 1'b0;
        req_data    = '0;
        wp_en_n     = 1'b0;
        nand_rnb    = 1'b0;
        nand_rnb2   = 1'b0;
        data_i      = '0;

        repeat (3) step();
        check_reset("reset");
        FAB_RESET_N = 1'b1;
        wp_en_n     = 1'b1;
        idle_cycles(2);

        run_op(0, 1'b0, 8'h70, 8'h00, 0, 1'b0, -1);
        run_op(3, 1'b0, 8'h00, 8'hE0, 0, 1'b0, -1);
        run_op(4, 1'b1, 8'h00, 8'h00, 10, 1'b0, -1);
        run_op(4, 1'b1, 8'h00, 8'h00, 100000, 1'b0, -1);

        run_op(0, 1'b0, 8'h00, 8'h00, 0, 1'b1, -1);
        for (int a = 0; a < 5; a++) run_op(1, 1'b0, 8'(8'h11 * (a + 1)), 8'h00, 0, 1'b1, -1);
        run_op(0, 1'b0, 8'h30, 8'h00, 0, 1'b1, -1);
        run_op(5, 1'b0, 8'h00, 8'h00, 0, 1'b0, -1);

        run_op(6, 1'b1, 8'hA5, 8'h00, 0, 1'b0, -1);
        run_op(7, 1'b0, 8'h5A, 8'h00, 0, 1'b0, -1);
        run_op(2, 1'b1, 8'hC3, 8'h00, 0, 1'b0, 1);
        run_op(0, 1'b1, 8'hFF, 8'h00, 0, 1'b0, -1);

        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
            run_op(int'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 22)), 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
